fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 124 ++++++++++++
 tb/tb_fetch_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch engine feeding a registered FIFO to decode.
// Issues sequential fetches, tags responses with their PC, flushes on redirect.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   imem_req/addr/ready       fetch request handshake (addr is the fetch PC)
//   imem_rvalid/rdata         response, exactly one cycle after acceptance
//   redirect, redirect_pc     flush queue and restart fetch at redirect_pc
//   instr_valid/instr/pc_out  head entry presented to decode
//   pcplus4_out               pc_out + 4 (wraps)
//   instr_ready               decode consumes the head
//   count                     occupied entries
module fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req,
  output logic [DATA_WIDTH-1:0]        imem_addr,
  input  logic                         imem_ready,
  input  logic                         imem_rvalid,
  input  logic [DATA_WIDTH-1:0]        imem_rdata,
  input  logic                         redirect,
  input  logic [DATA_WIDTH-1:0]        redirect_pc,
  output logic                         instr_valid,
  output logic [DATA_WIDTH-1:0]        instr,
  output logic [DATA_WIDTH-1:0]        pc_out,
  output logic [DATA_WIDTH-1:0]        pcplus4_out,
  input  logic                         instr_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] pc;
  } entry_t;

  entry_t                q [DEPTH];
  logic [PW-1:0]         rdPtr;
  logic [PW-1:0]         wrPtr;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] fetchPc;
  logic [DATA_WIDTH-1:0] flightPc;
  logic                  inflight;
  logic                  killed;

  logic                  room;
  logic                  accept;
  logic                  doPush;
  logic                  doPop;
  logic [CW:0]           reserved;

  // Entries already queued plus the one response still owed by memory.
  // Issuing only while this is below DEPTH guarantees every push fits.
  assign reserved = {1'b0, cnt} + (CW+1)'(inflight);
  assign room     = reserved < (CW+1)'(DEPTH);

  assign imem_req  = rst && room;
  assign imem_addr = fetchPc;
  assign accept    = imem_req && imem_ready;

  // Redirect wins over a same-cycle push or pop.
  assign doPush = imem_rvalid && inflight && !killed && !redirect;
  assign doPop  = instr_valid && instr_ready && !redirect;

  assign instr_valid = cnt != '0;
  assign instr       = q[rdPtr].word;
  assign pc_out      = q[rdPtr].pc;
  assign pcplus4_out = pc_out + DATA_WIDTH'(4);
  assign count       = cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetchPc  <= RESET_PC;
      flightPc <= '0;
      inflight <= 1'b0;
      killed   <= 1'b0;
      cnt      <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
    end else begin
      // A response always lands the cycle after acceptance, so the
      // previous request retires now and at most one is ever owed.
      inflight <= accept;
      killed   <= accept && redirect;
      if (accept) begin
        flightPc <= fetchPc;
      end
      if (redirect) begin
        fetchPc <= redirect_pc;
        cnt     <= '0;
        rdPtr   <= '0;
        wrPtr   <= '0;
      end else begin
        if (accept) begin
          fetchPc <= fetchPc + DATA_WIDTH'(4);
        end
        if (doPush) begin
          wrPtr <= wrPtr + PW'(1);
        end
        if (doPop) begin
          rdPtr <= rdPtr + PW'(1);
        end
        unique case (1'b1)
          doPush && !doPop: cnt <= cnt + CW'(1);
          doPop && !doPush: cnt <= cnt - CW'(1);
          default:          cnt <= cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      q[wrPtr] <= '{word: imem_rdata, pc: flightPc};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed table of per-cycle vectors plus wrap/sweep
// sequences on DEPTH=2 and DEPTH=8 instances.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imemReady;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        instrReady;
  logic        forceRv;

  int tests;
  int fails;

  // DEPTH=4, RESET_PC=0
  logic        req0, rv0, rvalid0, valid0;
  logic [31:0] addr0, rd0, instr0, pc0, pcp0;
  logic [2:0]  cnt0;

  // DEPTH=2, RESET_PC=0x8000_0000
  logic        req2, rv2, valid2;
  logic [31:0] addr2, rd2, instr2, pc2, pcp2;
  logic [1:0]  cnt2;

  // DEPTH=8, RESET_PC=0x8000_0000
  logic        req8, rv8, valid8;
  logic [31:0] addr8, rd8, instr8, pc8, pcp8;
  logic [3:0]  cnt8;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign rvalid0 = rv0 | forceRv;

  fetch_queue d0 (
    .clk(clk), .rst(rst),
    .imem_req(req0), .imem_addr(addr0), .imem_ready(imemReady),
    .imem_rvalid(rvalid0), .imem_rdata(rd0),
    .redirect(redirect), .redirect_pc(redirectPc),
    .instr_valid(valid0), .instr(instr0), .pc_out(pc0),
    .pcplus4_out(pcp0), .instr_ready(instrReady), .count(cnt0)
  );

  fetch_queue #(.DATA_WIDTH(32), .DEPTH(2), .RESET_PC(32'h8000_0000)) d2 (
    .clk(clk), .rst(rst),
    .imem_req(req2), .imem_addr(addr2), .imem_ready(imemReady),
    .imem_rvalid(rv2), .imem_rdata(rd2),
    .redirect(redirect), .redirect_pc(redirectPc),
    .instr_valid(valid2), .instr(instr2), .pc_out(pc2),
    .pcplus4_out(pcp2), .instr_ready(instrReady), .count(cnt2)
  );

  fetch_queue #(.DATA_WIDTH(32), .DEPTH(8), .RESET_PC(32'h8000_0000)) d8 (
    .clk(clk), .rst(rst),
    .imem_req(req8), .imem_addr(addr8), .imem_ready(imemReady),
    .imem_rvalid(rv8), .imem_rdata(rd8),
    .redirect(redirect), .redirect_pc(redirectPc),
    .instr_valid(valid8), .instr(instr8), .pc_out(pc8),
    .pcplus4_out(pcp8), .instr_ready(instrReady), .count(cnt8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: answers every accepted request one cycle later.
  initial begin
    rv0 = 1'b0;
    rv2 = 1'b0;
    rv8 = 1'b0;
    rd0 = '0;
    rd2 = '0;
    rd8 = '0;
  end

  always @(posedge clk) begin
    rv0 <= req0 && imemReady;
    rd0 <= memWord(addr0);
    rv2 <= req2 && imemReady;
    rd2 <= memWord(addr2);
    rv8 <= req8 && imemReady;
    rd8 <= memWord(addr8);
  end

  typedef struct {
    logic        rst;
    logic        iRdy;
    logic        inRdy;
    logic        redir;
    logic [31:0] rpc;
    logic        inj;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] ePc;
    int          eCnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(
    input logic rs, input logic ir, input logic nr,
    input logic rd, input logic [31:0] rp, input logic inj,
    input logic eq, input logic [31:0] ea, input logic ev,
    input logic [31:0] ep, input int ec
  );
    vec_t v;
    v.rst = rs; v.iRdy = ir; v.inRdy = nr;
    v.redir = rd; v.rpc = rp; v.inj = inj;
    v.eReq = eq; v.eAddr = ea; v.eValid = ev;
    v.ePc = ep; v.eCnt = ec;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  int n2;
  int n8;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    imemReady = 1'b1;
    instrReady = 1'b1;
    redirect = 1'b0;
    redirectPc = '0;
    forceRv = 1'b0;

    //  rst ir nr rd rpc         inj | req addr         v  pc            cnt
    add(0, 1, 1, 0, 32'h0,   0,  0, 32'h0,   0, 32'h0,   0);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h0,   0, 32'h0,   0);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h4,   0, 32'h0,   0);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h8,   1, 32'h0,   1);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'hC,   1, 32'h4,   1);
    add(1, 1, 0, 0, 32'h0,   0,  1, 32'h10,  1, 32'h8,   1);
    add(1, 1, 0, 0, 32'h0,   0,  1, 32'h14,  1, 32'h8,   2);
    add(1, 1, 0, 0, 32'h0,   0,  0, 32'h18,  1, 32'h8,   3);
    add(1, 1, 0, 0, 32'h0,   0,  0, 32'h18,  1, 32'h8,   4);
    add(1, 1, 0, 0, 32'h0,   0,  0, 32'h18,  1, 32'h8,   4);
    add(1, 1, 1, 0, 32'h0,   0,  0, 32'h18,  1, 32'h8,   4);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h18,  1, 32'hC,   3);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h1C,  1, 32'h10,  2);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h20,  1, 32'h14,  2);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h24,  1, 32'h18,  2);
    add(1, 1, 1, 1, 32'h100, 0,  1, 32'h28,  1, 32'h1C,  2);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h100, 0, 32'h0,   0);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h104, 0, 32'h0,   0);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h108, 1, 32'h100, 1);
    add(1, 1, 1, 1, 32'h200, 0,  1, 32'h10C, 1, 32'h104, 1);
    add(1, 1, 1, 1, 32'h300, 0,  1, 32'h200, 0, 32'h0,   0);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h300, 0, 32'h0,   0);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h304, 0, 32'h0,   0);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h308, 1, 32'h300, 1);
    add(0, 1, 1, 0, 32'h0,   0,  0, 32'h30C, 1, 32'h304, 1);
    add(1, 1, 1, 0, 32'h0,   1,  1, 32'h0,   0, 32'h0,   0);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h4,   0, 32'h0,   0);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h8,   1, 32'h0,   1);
    add(0, 1, 1, 0, 32'h0,   0,  0, 32'hC,   1, 32'h4,   1);
    add(1, 1, 0, 0, 32'h0,   0,  1, 32'h0,   0, 32'h0,   0);
    add(1, 1, 0, 0, 32'h0,   0,  1, 32'h4,   0, 32'h0,   0);
    add(1, 1, 0, 0, 32'h0,   0,  1, 32'h8,   1, 32'h0,   1);
    add(1, 1, 0, 0, 32'h0,   0,  1, 32'hC,   1, 32'h0,   2);
    add(1, 1, 0, 0, 32'h0,   0,  0, 32'h10,  1, 32'h0,   3);
    add(1, 1, 0, 0, 32'h0,   0,  0, 32'h10,  1, 32'h0,   4);
    add(1, 1, 0, 0, 32'h0,   0,  0, 32'h10,  1, 32'h0,   4);
    add(1, 0, 1, 0, 32'h0,   0,  0, 32'h10,  1, 32'h0,   4);
    add(1, 0, 1, 0, 32'h0,   0,  1, 32'h10,  1, 32'h4,   3);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h10,  1, 32'h8,   2);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h14,  1, 32'hC,   1);
    add(1, 1, 1, 0, 32'h0,   0,  1, 32'h18,  1, 32'h10,  1);

    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      rst        = vecs[i].rst;
      imemReady  = vecs[i].iRdy;
      instrReady = vecs[i].inRdy;
      redirect   = vecs[i].redir;
      redirectPc = vecs[i].rpc;
      forceRv    = vecs[i].inj;
      #1;
      chk($sformatf("r%0d.req", i), 32'(req0), 32'(vecs[i].eReq));
      chk($sformatf("r%0d.addr", i), addr0, vecs[i].eAddr);
      chk($sformatf("r%0d.valid", i), 32'(valid0), 32'(vecs[i].eValid));
      chk($sformatf("r%0d.count", i), 32'(cnt0), 32'(vecs[i].eCnt));
      if (vecs[i].eValid) begin
        chk($sformatf("r%0d.pc", i), pc0, vecs[i].ePc);
        chk($sformatf("r%0d.instr", i), instr0, memWord(vecs[i].ePc));
        chk($sformatf("r%0d.pc4", i), pcp0, vecs[i].ePc + 32'd4);
      end
      @(negedge clk);
    end

    // Sweep: DEPTH=2 / DEPTH=8, RESET_PC=0x8000_0000, wrap past 2^32.
    rst = 1'b0;
    imemReady = 1'b1;
    instrReady = 1'b0;
    redirect = 1'b0;
    forceRv = 1'b0;
    #1;
    chk("sw.rst.req2", 32'(req2), 32'd0);
    chk("sw.rst.req8", 32'(req8), 32'd0);
    @(negedge clk);

    rst = 1'b1;
    #1;
    chk("sw.addr2", addr2, 32'h8000_0000);
    chk("sw.addr8", addr8, 32'h8000_0000);
    chk("sw.req2", 32'(req2), 32'd1);
    chk("sw.req8", 32'(req8), 32'd1);
    chk("sw.cnt2", 32'(cnt2), 32'd0);
    @(negedge clk);

    redirect = 1'b1;
    redirectPc = 32'hFFFF_FFF8;
    #1;
    chk("sw.seq2", addr2, 32'h8000_0004);
    @(negedge clk);

    redirect = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    chk("sw.full2", 32'(cnt2), 32'd2);
    chk("sw.full8", 32'(cnt8), 32'd8);
    chk("sw.stop2", 32'(req2), 32'd0);
    chk("sw.stop8", 32'(req8), 32'd0);
    chk("sw.wrap2", addr2, 32'h0);
    chk("sw.wrap8", addr8, 32'h18);

    imemReady = 1'b0;
    instrReady = 1'b1;
    n2 = 0;
    n8 = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (valid2) begin
        chk($sformatf("d2.pc%0d", n2), pc2, 32'hFFFF_FFF8 + 32'(4 * n2));
        chk($sformatf("d2.in%0d", n2), instr2,
            memWord(32'hFFFF_FFF8 + 32'(4 * n2)));
        chk($sformatf("d2.p4%0d", n2), pcp2, 32'hFFFF_FFFC + 32'(4 * n2));
        n2++;
      end
      if (valid8) begin
        chk($sformatf("d8.pc%0d", n8), pc8, 32'hFFFF_FFF8 + 32'(4 * n8));
        chk($sformatf("d8.in%0d", n8), instr8,
            memWord(32'hFFFF_FFF8 + 32'(4 * n8)));
        n8++;
      end
      @(negedge clk);
    end
    #1;
    chk("d2.drained", 32'(n2), 32'd2);
    chk("d8.drained", 32'(n8), 32'd8);
    chk("d2.empty", 32'(cnt2), 32'd0);
    chk("d8.empty", 32'(cnt8), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
